seq_priority_encoder: RTL and testbench
=======================================

// Module: seq_priority_encoder
//
// PURPOSE
//  Parametrised, sequential successor to the 8x3 gate-level encoder.
//  - Accepts a WIDTH-bit one-hot or multi-hot request vector over a valid/ready handshake.
//  - Emits the index of every set bit, one per output beat, in priority order.
//  - Sits between request sources (interrupt lines, arbiter grants) and a consumer
//    that handles one index at a time.
//  - An all-zero vector produces one explicit "none" beat; it is never silently dropped.
//
// PARAMETERS
//  WIDTH      8   number of request bits; any value >= 2
//  MSB_FIRST  0   0: emit lowest set index first; 1: emit highest set index first
//  IDX_W      $clog2(WIDTH)   localparam; width of out_index
//
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      in_data is valid
//  in_ready   out  1      block can accept a vector
//  in_data    in   WIDTH  request vector
//  out_valid  out  1      out_index/out_last/out_none are valid
//  out_ready  in   1      consumer accepts the current beat
//  out_index  out  IDX_W  index of the current highest-priority pending bit
//  out_last   out  1      this is the final beat for the accepted vector
//  out_none   out  1      accepted vector was all-zero (out_index = 0, out_last = 1)
//
// BEHAVIOUR
//  - Reset (async assert, sync release):
//    pending = 0, state = IDLE, in_ready = 1, out_valid = 0,
//    out_index = 0, out_last = 0, out_none = 0.
//  - States:
//    IDLE: in_ready = 1, out_valid = 0.
//      in_valid & in_ready -> pending <= in_data, zero_flag <= (in_data == 0), go to EMIT.
//    EMIT: in_ready = 0, out_valid = 1.
//      out_valid & out_ready -> clear the emitted bit in pending.
//      If out_last, return to IDLE.
//  - Output decode is driven from registered state only; there is no combinational
//    path from in_* to out_*.
//    - out_index: lowest set bit of pending (MSB_FIRST = 0) or highest set bit (MSB_FIRST = 1).
//    - out_last = zero_flag | (pending has exactly one bit set).
//    - out_none = zero_flag.
//  - Latency: vector accepted at edge t -> first beat has out_valid = 1 after edge t.
//    One beat per cycle while out_ready = 1.
//  - Throughput: popcount(in_data) beats (minimum 1), plus one IDLE cycle, per vector.
//    in_ready is never asserted in the same cycle as out_valid.
//  - Backpressure: while out_valid & !out_ready, out_index, out_last and out_none
//    hold stable and pending is unchanged.
//  - in_data is ignored whenever in_ready = 0 (no buffering beyond one vector).
//  - Boundary cases:
//    - Single bit set: exactly one beat, out_last = 1.
//    - All WIDTH bits set: WIDTH beats; indices 0..WIDTH-1 (or reversed).
//    - Bit WIDTH-1 set with WIDTH not a power of two: index WIDTH-1 is
//      representable in IDX_W bits.
//  - Reset mid-EMIT: pending is discarded, and no further beats are produced for
//    that vector.
//
// TESTING
//  1. WIDTH=8, LSB-first, in_data = 8'b00000001, out_ready = 1
//     -> one beat: idx 0, last = 1, none = 0; in_ready high on the following cycle.
//  2. in_data = 8'b10010110, out_ready = 1
//     -> beats on consecutive cycles: idx 1, 2, 4, 7; last = 1 only on idx 7.
//  3. in_data = 8'b00001000, out_ready held low 3 cycles, then high
//     -> idx 3 stable for 4 cycles; exactly one beat consumed; in_ready stays 0 until done.
//  4. in_data = 8'h00
//     -> one beat: none = 1, last = 1, idx 0; return to IDLE.
//  5. in_data = 8'hFF; assert rst after the 3rd beat
//     -> out_valid = 0 immediately; in_ready = 1 after release; next vector 8'b00000010 -> idx 1.
//  6. WIDTH=16, MSB_FIRST=1, in_data = 16'h8001
//     -> beats idx 15 then idx 0 (last); WIDTH=5, in_data = 5'b10000 -> idx 4, last = 1.

Source files
------------

// File: rtl/seq_priority_encoder.sv
// Sequential priority encoder: accepts a request vector over valid/ready and emits the
// index of every set bit, one beat at a time, in priority order (all-zero gives one "none" beat).
module seq_priority_encoder #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0,
    localparam int IDX_W    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last,
    output logic             out_none
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] pending_reg, pending_next;
    logic             zero_flag_reg, zero_flag_next;

    logic [IDX_W-1:0] sel_index;
    logic [WIDTH-1:0] sel_onehot;
    logic             single_bit;
    logic             last_beat;

    // Later iterations overwrite earlier ones, so scan toward the winning end last.
    always_comb begin
        sel_index = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (MSB_FIRST) begin
                if (pending_reg[i]) begin
                    sel_index = IDX_W'(i);
                end
            end else begin
                if (pending_reg[WIDTH-1-i]) begin
                    sel_index = IDX_W'(WIDTH-1-i);
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_onehot
            assign sel_onehot[gi] = (sel_index == IDX_W'(gi));
        end
    endgenerate

    assign single_bit = (pending_reg != '0) &&
                        ((pending_reg & (pending_reg - WIDTH'(1))) == '0);
    assign last_beat  = zero_flag_reg | single_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            pending_reg   <= '0;
            zero_flag_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pending_reg   <= pending_next;
            zero_flag_reg <= zero_flag_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        pending_next   = pending_reg;
        zero_flag_next = zero_flag_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    pending_next   = in_data;
                    zero_flag_next = (in_data == '0);
                    state_next     = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    pending_next = pending_reg & ~sel_onehot;
                    if (last_beat) begin
                        zero_flag_next = 1'b0;
                        state_next     = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs depend only on registered state, never on the input handshake.
    always_comb begin
        in_ready  = (state_reg == IDLE);
        out_valid = (state_reg == EMIT);
        out_index = '0;
        out_last  = 1'b0;
        out_none  = 1'b0;
        if (state_reg == EMIT) begin
            out_index = sel_index;
            out_last  = last_beat;
            out_none  = zero_flag_reg;
        end
    end

endmodule

// File: tb/tb_seq_priority_encoder.sv
// Directed bench for seq_priority_encoder: three instances (8 LSB-first, 16 MSB-first, 5 LSB-first)
// checked against a queue of expected beats built from each driven vector.
module tb_seq_priority_encoder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int          sel = 0;
    logic        in_valid_drv = 1'b0;
    logic [15:0] data_drv = '0;
    logic        out_ready_drv = 1'b0;

    logic       ir8, ov8, ol8, on8;
    logic [2:0] oi8;
    logic       ir16, ov16, ol16, on16;
    logic [3:0] oi16;
    logic       ir5, ov5, ol5, on5;
    logic [2:0] oi5;

    seq_priority_encoder #(.WIDTH(8), .MSB_FIRST(1'b0)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_drv && (sel == 0)), .in_ready(ir8), .in_data(data_drv[7:0]),
        .out_valid(ov8), .out_ready(out_ready_drv && (sel == 0)),
        .out_index(oi8), .out_last(ol8), .out_none(on8)
    );

    seq_priority_encoder #(.WIDTH(16), .MSB_FIRST(1'b1)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_drv && (sel == 1)), .in_ready(ir16), .in_data(data_drv),
        .out_valid(ov16), .out_ready(out_ready_drv && (sel == 1)),
        .out_index(oi16), .out_last(ol16), .out_none(on16)
    );

    seq_priority_encoder #(.WIDTH(5), .MSB_FIRST(1'b0)) dut5 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_drv && (sel == 2)), .in_ready(ir5), .in_data(data_drv[4:0]),
        .out_valid(ov5), .out_ready(out_ready_drv && (sel == 2)),
        .out_index(oi5), .out_last(ol5), .out_none(on5)
    );

    logic        cur_in_ready, cur_out_valid, cur_out_last, cur_out_none;
    logic [31:0] cur_out_index;

    always_comb begin
        case (sel)
            1: begin
                cur_in_ready = ir16; cur_out_valid = ov16; cur_out_last = ol16;
                cur_out_none = on16; cur_out_index = 32'(oi16);
            end
            2: begin
                cur_in_ready = ir5; cur_out_valid = ov5; cur_out_last = ol5;
                cur_out_none = on5; cur_out_index = 32'(oi5);
            end
            default: begin
                cur_in_ready = ir8; cur_out_valid = ov8; cur_out_last = ol8;
                cur_out_none = on8; cur_out_index = 32'(oi8);
            end
        endcase
    end

    typedef struct {
        int idx;
        bit last;
        bit none;
    } beat_t;

    beat_t sb[$];
    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_expect(input int width, input bit msb, input logic [15:0] data);
        int    cnt;
        int    n;
        int    pos;
        beat_t b;
        cnt = 0;
        n   = 0;
        for (int i = 0; i < width; i++) if (data[i]) cnt++;
        if (cnt == 0) begin
            b.idx = 0; b.last = 1'b1; b.none = 1'b1;
            sb.push_back(b);
        end else begin
            for (int k = 0; k < width; k++) begin
                pos = msb ? (width - 1 - k) : k;
                if (data[pos]) begin
                    n++;
                    b.idx = pos; b.last = (n == cnt); b.none = 1'b0;
                    sb.push_back(b);
                end
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1.
    task automatic run_vector(input int sel_i, input logic [15:0] data, input int stall,
                              input bit noise, input int abort_after);
        int width;
        bit msb;
        int beats;
        int budget;
        int stall_left;
        width = (sel_i == 1) ? 16 : (sel_i == 2) ? 5 : 8;
        msb   = (sel_i == 1);
        sel   = sel_i;
        out_ready_drv = 1'b1;
        for (int i = 0; i < 20 && !cur_in_ready; i++) begin
            @(posedge clk); #1;
        end
        check("in_ready_before_accept", 32'(cur_in_ready), 32'd1);
        push_expect(width, msb, data);
        in_valid_drv = 1'b1;
        data_drv     = data;
        @(posedge clk); #1;
        in_valid_drv = 1'b0;
        beats      = 0;
        budget     = 64;
        stall_left = stall;
        while (sb.size() > 0 && budget > 0 && !(abort_after > 0 && beats == abort_after)) begin
            out_ready_drv = (stall_left == 0);
            if (noise) begin
                in_valid_drv = 1'b1;
                data_drv     = 16'($urandom);
            end
            check("out_valid", 32'(cur_out_valid), 32'd1);
            check("in_ready_low", 32'(cur_in_ready), 32'd0);
            check("out_index", cur_out_index, 32'(sb[0].idx));
            check("out_last", 32'(cur_out_last), 32'(sb[0].last));
            check("out_none", 32'(cur_out_none), 32'(sb[0].none));
            if (stall_left == 0) begin
                void'(sb.pop_front());
                beats++;
            end else begin
                stall_left--;
            end
            @(posedge clk); #1;
            budget--;
        end
        in_valid_drv  = 1'b0;
        out_ready_drv = 1'b1;
        if (abort_after == 0) begin
            check("beats_left", 32'(sb.size()), 32'd0);
            check("idle_out_valid", 32'(cur_out_valid), 32'd0);
            check("idle_in_ready", 32'(cur_in_ready), 32'd1);
            $display("[TB] vector %h on dut %0d: %0d beats consumed", data, sel_i, beats);
        end
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(cur_in_ready), 32'd1);
        check("rst_out_valid", 32'(cur_out_valid), 32'd0);
        check("rst_out_index", cur_out_index, 32'd0);
        check("rst_out_last", 32'(cur_out_last), 32'd0);
        check("rst_out_none", 32'(cur_out_none), 32'd0);
        check("rst_in_ready16", 32'(ir16), 32'd1);
        check("rst_in_ready5", 32'(ir5), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        run_vector(0, 16'h0001, 0, 1'b0, 0);
        run_vector(0, 16'h0096, 0, 1'b0, 0);
        run_vector(0, 16'h0008, 3, 1'b1, 0);
        run_vector(0, 16'h0000, 0, 1'b0, 0);

        // Reset in the middle of emitting an all-ones vector.
        run_vector(0, 16'h00FF, 0, 1'b0, 3);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(cur_out_valid), 32'd0);
        check("midrst_in_ready", 32'(cur_in_ready), 32'd1);
        $display("[TB] reset asserted after 3 beats, %0d expected beats discarded", sb.size());
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("postrst_out_valid", 32'(cur_out_valid), 32'd0);
        run_vector(0, 16'h0002, 0, 1'b0, 0);
        run_vector(0, 16'h00FF, 0, 1'b0, 0);

        run_vector(1, 16'h8001, 0, 1'b0, 0);
        run_vector(1, 16'hFFFF, 1, 1'b0, 0);
        run_vector(2, 16'h0010, 0, 1'b0, 0);
        run_vector(2, 16'h0015, 0, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
